pipe_cla_adder: RTL and testbench
=================================

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4, pipeline depth; chunk width CW = WIDTH/STAGES; STAGES >= 1.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  pipeline can accept a beat this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 cin  input  1  carry-in, used when sub=0.
REQ-009 sub  input  1  0: a+b+cin; 1: a-b, i.e. a+~b+1, cin ignored.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of MSB; for sub, 1 means no borrow.
REQ-014 ovf  output  1  signed overflow.
REQ-015 zero  output  1  sum == 0.

Function
REQ-016 Stage k (0..STAGES-1) SHALL add operand chunk k (bits k*CW+CW-1 : k*CW) using per-bit g=a&b, p=a|b lookahead within the chunk; carry into chunk k SHALL be the registered carry-out of stage k-1 (stage 0: cin or 1 for sub).
REQ-017 Upper operand chunks SHALL be delay-registered so chunk k enters its adder exactly k cycles after acceptance; lower result chunks SHALL be delay-registered so all chunks emerge aligned.
REQ-018 Latency SHALL be exactly STAGES cycles from accepted beat (in_valid & in_ready) to out_valid, with no stalls.
REQ-019 Throughput SHALL be one beat per cycle when out_ready stays high.
REQ-020 Stall: when out_valid=1 and out_ready=0, the whole pipeline SHALL hold; in_ready = !(out_valid & !out_ready).
REQ-021 Beats SHALL emerge in acceptance order; no beat is dropped or duplicated; bubbles (in_valid=0) propagate as invalid slots.
REQ-022 sum, cout, ovf, zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 ovf = carry into MSB XOR carry out of MSB of the final chunk.
REQ-024 Simultaneous accept and drain in a full pipeline SHALL advance all stages by one, with no loss.
REQ-025 STAGES=1 SHALL degenerate to one registered adder, latency 1.

Reset
REQ-026 When rst_n=0 at a rising edge, all valid bits SHALL clear; out_valid=0, sum=0, cout=0, ovf=0, zero=0 on the following cycle.
REQ-027 in_ready SHALL be 1 out of reset.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; no stale beat appears after reset deasserts.
REQ-029 Data registers other than outputs need not be reset; valid bits gate them.

Configuration
REQ-030 Macro PIPE_CLA_ADDER_FLAGS_EN: defined: ovf and zero computed per REQ-015/REQ-023 and pipelined with sum.
REQ-031 Undefined: ovf and zero SHALL be tied 0, their logic and registers omitted; sum/cout behaviour unchanged.

Verification (WIDTH=32, STAGES=4, FLAGS_EN defined unless noted)
REQ-032 Reset, then a=0x0000FFFF, b=0x00000001, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles later, sum=0x00010000, cout=0, ovf=0, zero=0.
REQ-033 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1, cout=0; a=0x00000005, b=0x00000005, sub=1 -> sum=0, zero=1, cout=1.
REQ-034 Ripple across all chunks: a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, zero=1.
REQ-035 10 back-to-back beats, out_ready low cycles 3-5 after first output -> in_ready low exactly while stalled, all 10 results in order and correct, outputs stable during stall.
REQ-036 Accept 3 beats, assert rst_n=0 for one cycle mid-flight -> no out_valid ever for those beats; next beat after reset has latency 4.
REQ-037 Build without PIPE_CLA_ADDER_FLAGS_EN, repeat REQ-033 -> ovf=0 and zero=0, sum/cout identical.

Source files
------------

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: pipelined carry-lookahead adder/subtractor.
//
// The WIDTH-bit operation is split into STAGES chunks of CW = WIDTH/STAGES
// bits. Stage k adds chunk k with in-chunk lookahead carries. Its carry-in
// comes from the registered carry-out of stage k-1. Upper operand chunks and
// lower result chunks travel through delay registers so that every chunk of a
// beat emerges together, STAGES cycles after acceptance. A stall at the
// output holds the whole pipeline.
//
// Optional feature: define PIPE_CLA_ADDER_FLAGS_EN to compute and pipeline
// the ovf and zero flags. Without it both flags are tied low.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand beat offered
//   in_ready   pipeline accepts a beat this cycle
//   a, b       operands (WIDTH)
//   cin        carry-in for add (ignored for sub)
//   sub        0: a+b+cin, 1: a-b (a+~b+1)
//   out_valid  result beat present
//   out_ready  consumer accepts the result
//   sum        result (WIDTH)
//   cout       carry out of MSB (for sub: 1 = no borrow)
//   ovf        signed overflow
//   zero       sum == 0
module pipe_cla_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Chunk adder. Each carry is a flat sum-of-products over g/p terms, so no
  // carry ripples bit-to-bit inside the chunk.
  // Result: {carry out, carry into chunk MSB, chunk sum}.
  function automatic logic [CW+1:0] cla(input logic [CW-1:0] x,
                                        input logic [CW-1:0] y,
                                        input logic          ci);
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW:0]   c;
    logic          t;
    g    = x & y;
    p    = x | y;
    c    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < CW; i++) begin
      t = ci;
      for (int unsigned k = 0; k <= i; k++) t = t & p[k];
      c[i+1] = t;
      for (int unsigned j = 0; j <= i; j++) begin
        t = g[j];
        for (int unsigned k = j + 1; k <= i; k++) t = t & p[k];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[CW], c[CW-1], x ^ y ^ c[CW-1:0]};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [CW+1:0]    st    [STAGES];
  logic             vin   [STAGES];

  // [stage][chunk]: pipeline register of stage s holding chunk k.
  // Operands: only chunks k > s are meaningful; results: only k <= s.
  logic [CW-1:0]    opa_q [STAGES][STAGES];
  logic [CW-1:0]    opb_q [STAGES][STAGES];
  logic [CW-1:0]    res_q [STAGES][STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];
`ifdef PIPE_CLA_ADDER_FLAGS_EN
  // Running "all chunks so far are zero" flag, one per stage.
  logic             z_q   [STAGES];
  logic             ovf_q;
`endif

  assign out_valid = v_q[LAST];
  assign in_ready  = !(out_valid && !out_ready);
  assign adv       = in_ready;
  assign cout      = c_q[LAST];

  always_comb begin
    b_eff  = sub ? ~b : b;
    c0     = sub | cin;
    st[0]  = cla(a[CW-1:0], b_eff[CW-1:0], c0);
    vin[0] = in_valid;
    for (int unsigned s = 1; s < STAGES; s++) begin
      st[s]  = cla(opa_q[s-1][s], opb_q[s-1][s], c_q[s-1]);
      vin[s] = v_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) v_q[s] <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) res_q[LAST][k] <= '0;
      c_q[LAST] <= 1'b0;
`ifdef PIPE_CLA_ADDER_FLAGS_EN
      z_q[LAST] <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else if (adv) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        v_q[s] <= vin[s];
        // The output stage loads only on a real beat, so sum/cout/flags keep
        // their reset or last value across bubbles.
        if (s != LAST || vin[s]) begin
          c_q[s]      <= st[s][CW+1];
          res_q[s][s] <= st[s][CW-1:0];
          for (int unsigned k = 0; k < s; k++) res_q[s][k] <= res_q[s-1][k];
          for (int unsigned k = s + 1; k < STAGES; k++) begin
            if (s == 0) begin
              opa_q[s][k] <= a[k*CW +: CW];
              opb_q[s][k] <= b_eff[k*CW +: CW];
            end else begin
              opa_q[s][k] <= opa_q[s-1][k];
              opb_q[s][k] <= opb_q[s-1][k];
            end
          end
`ifdef PIPE_CLA_ADDER_FLAGS_EN
          if (s == 0) z_q[s] <= (st[s][CW-1:0] == '0);
          else        z_q[s] <= z_q[s-1] && (st[s][CW-1:0] == '0);
          if (s == LAST) ovf_q <= st[s][CW+1] ^ st[s][CW];
`endif
        end
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < STAGES; k++) sum[k*CW +: CW] = res_q[LAST][k];
  end

`ifdef PIPE_CLA_ADDER_FLAGS_EN
  assign ovf  = ovf_q;
  assign zero = z_q[LAST];
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Testbench for pipe_cla_adder (WIDTH=32, STAGES=4). The reference model
// computes results with plain arithmetic. A slot array models the fixed-latency
// pipeline with a global stall.
module tb_pipe_cla_adder;
  localparam int W  = 32;
  localparam int ST = 4;
  localparam int L  = ST - 1;
`ifdef PIPE_CLA_ADDER_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic         cout, ovf, zero;
  logic [W-1:0] a, b, sum;

  int n_vec = 0;
  int n_err = 0;
  int dut_drained = 0;
  int n_rdy_low = 0;
  logic live = 1'b0;
  logic         mv   [ST];
  logic [W+2:0] mres [ST];   // {cout, ovf, zero, sum}

  pipe_cla_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W+2:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
    logic [W-1:0] ye;
    logic [W:0]   full;
    logic         o, z;
    ye   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (s | ci)};
    o    = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
    z    = (full[W-1:0] == '0);
    return {full[W], o & FL, z & FL, full[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic is, input logic ordy, input logic irst);
    logic erdy;
    rst_n = irst; in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = ordy;
    #1;
    erdy = !(mv[L] && !ordy);
    if (live) begin
      chk("in_ready", 64'(in_ready), 64'(erdy));
      chk("out_valid", 64'(out_valid), 64'(mv[L]));
      if (mv[L]) chk("result", 64'({cout, ovf, zero, sum}), 64'(mres[L]));
      if (out_valid && ordy) dut_drained++;
      if (!in_ready) n_rdy_low++;
    end
    @(posedge clk);
    if (!irst) begin
      for (int s = 0; s < ST; s++) mv[s] = 1'b0;
      live = 1'b1;
    end else if (erdy) begin
      for (int s = L; s > 0; s--) begin
        mv[s]   = mv[s-1];
        mres[s] = mres[s-1];
      end
      mv[0]   = iv;
      mres[0] = ref_add(ia, ib, ic, is);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  // One beat, then check it appears exactly ST cycles after acceptance.
  task automatic directed(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, input logic is, input logic [W+2:0] expv);
    cycle(1'b1, ia, ib, ic, is, 1'b1, 1'b1);
    idle(ST - 1);
    chk({tag, "_latency"}, 64'(out_valid), 64'(1'b1));
    chk(tag, 64'({cout, ovf, zero, sum}), 64'(expv));
    idle(1);
  endtask

  initial begin
    logic [W-1:0] va [10];
    logic [W-1:0] vb [10];
    logic         vc [10];
    logic         vs [10];
    logic [W-1:0] ra, rb;
    logic         ordy, iv, acc;
    int           sent, first, idx;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    for (int s = 0; s < ST; s++) begin
      mv[s] = 1'b0;
      mres[s] = '0;
    end

    // Reset state
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed corner cases
    directed("carry_chunk", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0,
             {1'b0, 1'b0, 1'b0, 32'h00010000});
    directed("signed_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
             {1'b0, FL, 1'b0, 32'h80000000});
    directed("sub_zero", 32'h00000005, 32'h00000005, 1'b1, 1'b1,
             {1'b1, 1'b0, FL, 32'h00000000});
    directed("full_ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0,
             {1'b1, 1'b0, FL, 32'h00000000});

    // Ten back-to-back beats, output stalled on cycles 3..5 after first output
    for (int i = 0; i < 10; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vc[i] = 1'($urandom_range(0, 1));
      vs[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; first = -1; dut_drained = 0; n_rdy_low = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (first < 0 && mv[L]) first = cyc;
      ordy = !(first >= 0 && cyc >= first + 3 && cyc <= first + 5);
      iv   = (sent < 10);
      idx  = (sent < 10) ? sent : 0;
      acc  = iv && !(mv[L] && !ordy);
      cycle(iv, va[idx], vb[idx], vc[idx], vs[idx], ordy, 1'b1);
      if (acc) sent++;
    end
    chk("b2b_drained", 64'(dut_drained), 64'(10));
    chk("b2b_stall_cycles", 64'(n_rdy_low), 64'(3));

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    dut_drained = 0;
    idle(6);
    chk("no_stale_after_rst", 64'(dut_drained), 64'(0));
    directed("post_rst", 32'h00001234, 32'h00000001, 1'b0, 1'b0,
             {1'b0, 1'b0, 1'b0, 32'h00001235});

    // Random traffic with bubbles and back-pressure
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = 32'hFFFFFFFF;
        1:       ra = 32'h7FFFFFFF;
        2:       ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b1);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
